// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver feeding a show-ahead byte FIFO.
// The PS/2 clock and data pins are synchronised into the system clock
// domain. Frames are deserialised on falling edges of the synchronised PS/2
// clock, and accepted scancode bytes are queued for the bus. The bus sees
// the head byte, a ready flag and the last four accepted bytes.
//
// Build option: define PS2_RX_PARITY_CHECK_EN to drop bytes that fail the
// odd-parity check. Without it, the parity bit is captured and then ignored.

module ps2_kbd_rx #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        PS2_clk,
    input  logic        PS2_data,
    input  logic        ps2_rd,
    input  logic        clr_err,
    output logic [7:0]  key,
    output logic        ps2_ready,
    output logic        overflow,
    output logic        frame_err,
    output logic [31:0] Scancode
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]      TMO_ONE  = TW'(1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity holds when the 8 data bits plus the parity bit contain an
    // odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic ps2c_meta_r, ps2c_sync_r, ps2c_prev_r;
    logic ps2d_meta_r, ps2d_sync_r;
    logic fe_s;
    logic data_s;

    // Two-flop synchronisers on both pins, plus a delayed copy of the clock
    // used for falling-edge detection. Idle-high values out of reset.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            ps2c_meta_r <= 1'b1;
            ps2c_sync_r <= 1'b1;
            ps2c_prev_r <= 1'b1;
            ps2d_meta_r <= 1'b1;
            ps2d_sync_r <= 1'b1;
        end else begin
            ps2c_meta_r <= PS2_clk;
            ps2c_sync_r <= ps2c_meta_r;
            ps2c_prev_r <= ps2c_sync_r;
            ps2d_meta_r <= PS2_data;
            ps2d_sync_r <= ps2d_meta_r;
        end
    end

    assign fe_s   = ps2c_prev_r & ~ps2c_sync_r;
    assign data_s = ps2d_sync_r;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_r, state_nxt_s;
    logic [2:0]    bitcnt_r, bitcnt_nxt_s;
    logic [7:0]    shift_r, shift_nxt_s;
    logic          parity_r, parity_nxt_s;
    logic          push_r, push_nxt_s;
    logic [7:0]    push_byte_r;
    logic          frame_err_r, err_nxt_s;
    logic [TW-1:0] tmo_cnt_r;
    logic          tmo_hit_s;
    logic          parity_pass_s;

`ifdef PS2_RX_PARITY_CHECK_EN
    assign parity_pass_s = odd_parity_ok(shift_r, parity_r);
`else
    assign parity_pass_s = 1'b1;
`endif

    assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_cnt_r == TMO_LAST);

    // Inactivity counter: it restarts on every PS/2 falling edge and only
    // runs while a frame is in progress.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            tmo_cnt_r <= '0;
        end else if (fe_s || (state_r == ST_IDLE)) begin
            tmo_cnt_r <= '0;
        end else if (tmo_cnt_r != TMO_LAST) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Next-state logic. A PS/2 falling edge advances the frame. A timeout
    // abandons the partial frame and reports an error.
    always_comb begin
        state_nxt_s  = state_r;
        bitcnt_nxt_s = bitcnt_r;
        shift_nxt_s  = shift_r;
        parity_nxt_s = parity_r;
        push_nxt_s   = 1'b0;
        err_nxt_s    = 1'b0;
        if (fe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_nxt_s  = ST_DATA;
                        bitcnt_nxt_s = 3'd0;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_nxt_s = {data_s, shift_r[7:1]};
                    if (bitcnt_r == 3'd7) begin
                        state_nxt_s  = ST_PARITY;
                        bitcnt_nxt_s = 3'd0;
                    end else begin
                        bitcnt_nxt_s = bitcnt_r + 3'd1;
                    end
                end
                ST_PARITY: begin
                    parity_nxt_s = data_s;
                    state_nxt_s  = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt_s = ST_IDLE;
                    if (data_s && parity_pass_s) begin
                        push_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else if (tmo_hit_s) begin
            state_nxt_s  = ST_IDLE;
            bitcnt_nxt_s = 3'd0;
            shift_nxt_s  = 8'h00;
            err_nxt_s    = 1'b1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and datapath registers. The push request and the byte are
    // registered, so the FIFO write lands one cycle after the stop bit.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_r     <= ST_IDLE;
            bitcnt_r    <= 3'd0;
            shift_r     <= 8'h00;
            parity_r    <= 1'b0;
            push_r      <= 1'b0;
            push_byte_r <= 8'h00;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bitcnt_r    <= bitcnt_nxt_s;
            shift_r     <= shift_nxt_s;
            parity_r    <= parity_nxt_s;
            push_r      <= push_nxt_s;
            frame_err_r <= err_nxt_s;
            if (push_nxt_s) begin
                push_byte_r <= shift_r;
            end else begin
                push_byte_r <= push_byte_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, wr_ptr_nxt_s;
    logic [FIFO_AW-1:0] rd_ptr_r, rd_ptr_nxt_s;
    logic [FIFO_AW:0]   count_r, count_nxt_s;
    logic [7:0]         key_r, key_nxt_s;
    logic               ready_r;
    logic               overflow_r;
    logic [31:0]        scancode_r;
    logic               full_s, pop_s, wr_en_s, ovf_evt_s;

    assign full_s    = (count_r == FULL_CNT);
    assign pop_s     = ps2_rd & ready_r;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign wr_en_s   = push_r & (~full_s | pop_s);
    assign ovf_evt_s = push_r & full_s & ~pop_s;

    // Pointer and count updates, plus the head byte that will be presented
    // after this edge. The pushed byte is bypassed when it becomes the head.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        key_nxt_s    = 8'h00;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (count_nxt_s == '0) begin
            key_nxt_s = 8'h00;
        end else if (wr_en_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            key_nxt_s = push_byte_r;
        end else begin
            key_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage. There is no reset: reads are qualified by the count.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_byte_r;
        end
    end

    // FIFO control registers and the registered bus-facing head/ready outputs.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            key_r    <= 8'h00;
            ready_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            key_r    <= key_nxt_s;
            ready_r  <= (count_nxt_s != '0);
        end
    end

    // Sticky overflow flag. A new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            overflow_r <= 1'b0;
        end else if (ovf_evt_s) begin
            overflow_r <= 1'b1;
        end else if (clr_err) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Scancode history tracks every accepted byte, even one dropped for lack of room.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            scancode_r <= 32'h0000_0000;
        end else if (push_r) begin
            scancode_r <= {scancode_r[23:0], push_byte_r};
        end else begin
            scancode_r <= scancode_r;
        end
    end

    assign key       = key_r;
    assign ps2_ready = ready_r;
    assign overflow  = overflow_r;
    assign frame_err = frame_err_r;
    assign Scancode  = scancode_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx. A model of the FIFO contents, the Scancode history,
// the overflow flag and the error count is kept as queues and counters. A
// monitor checks every popped byte against the expected-byte queue.
`timescale 1ns/1ps

module tb_ps2_kbd_rx;

    localparam int TMO  = 400;
    localparam int HALF = 20;

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        PS2_clk = 1'b1;
    logic        PS2_data = 1'b1;
    logic        ps2_rd = 1'b0;
    logic        clr_err = 1'b0;
    logic [7:0]  key;
    logic        ps2_ready;
    logic        overflow;
    logic        frame_err;
    logic [31:0] Scancode;

    ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .RSTN(RSTN), .PS2_clk(PS2_clk), .PS2_data(PS2_data),
        .ps2_rd(ps2_rd), .clr_err(clr_err), .key(key), .ps2_ready(ps2_ready),
        .overflow(overflow), .frame_err(frame_err), .Scancode(Scancode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] scan_m = 32'h0;
    logic        ovf_m = 1'b0;
    int          err_m = 0;
    int          ferr_pulses = 0;
    int          ferr_cycles = 0;
    logic        ferr_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: count frame_err activity, and score every byte the bus pops.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err && !ferr_prev) ferr_pulses++;
            if (frame_err) ferr_cycles++;
            ferr_prev = frame_err;
            if (ps2_rd && ps2_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=%0h required=none", key);
                end else begin
                    check("pop_key", {24'h0, key}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic ps2_bit(input logic b);
        PS2_data = b;
        repeat (HALF) @(posedge clk);
        #1 PS2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 PS2_clk = 1'b1;
    endtask

    // One PS/2 frame. The model is updated at the stop-bit falling edge. With
    // pop_at_stop, the read strobe is timed to land on the FIFO write cycle.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit pop_at_stop);
        logic par;
        bit   accept;
        par = (~^d) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        PS2_data = ~bad_stop;
        repeat (HALF) @(posedge clk);
        #1 PS2_clk = 1'b0;
        accept = !bad_stop && !(bad_par && PAR_EN);
        if (accept) begin
            scan_m = {scan_m[23:0], d};
            if (exp_q.size() < 8 || pop_at_stop) exp_q.push_back(d);
            else ovf_m = 1'b1;
        end else begin
            err_m++;
        end
        if (pop_at_stop) begin
            repeat (3) @(posedge clk);
            #1 ps2_rd = 1'b1;
            @(posedge clk);
            #1 ps2_rd = 1'b0;
            repeat (HALF - 4) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 PS2_clk = 1'b1;
        PS2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        #1;
    endtask

    task automatic pop();
        @(posedge clk);
        #1 ps2_rd = 1'b1;
        @(posedge clk);
        #1 ps2_rd = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (ps2_ready && guard < 16) begin
            pop();
            guard++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ready"}, {31'h0, ps2_ready}, {31'h0, exp_q.size() != 0});
        check({tag, "_key"}, {24'h0, key}, (exp_q.size() != 0) ? {24'h0, exp_q[0]} : 32'h0);
        check({tag, "_scan"}, Scancode, scan_m);
        check({tag, "_ovf"}, {31'h0, overflow}, {31'h0, ovf_m});
        check({tag, "_ferr_pulses"}, ferr_pulses, err_m);
        check({tag, "_ferr_cycles"}, ferr_cycles, err_m);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_key", {24'h0, key}, 32'h0);
        check("rst_ready", {31'h0, ps2_ready}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_scan", Scancode, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        RSTN = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single valid frame.
        send_frame(8'h1C, 0, 0, 0);
        check("tp1_key", {24'h0, key}, 32'h1C);
        check("tp1_scan", Scancode, 32'h0000_001C);
        check_state("tp1");
        drain();
        check_state("tp1_drained");

        // Two frames, then pop them one at a time.
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        check("tp2_key0", {24'h0, key}, 32'hF0);
        check("tp2_scan", Scancode, 32'h001C_F01C);
        pop();
        check("tp2_key1", {24'h0, key}, 32'h1C);
        pop();
        check("tp2_ready_empty", {31'h0, ps2_ready}, 32'h0);
        check("tp2_key_empty", {24'h0, key}, 32'h0);

        // Wrong parity bit.
        send_frame(8'h1C, 1, 0, 0);
        check_state("par");
        drain();

        // Stray falling edge in IDLE with data high, then a bad stop bit.
        ps2_bit(1'b1);
        err_m++;
        repeat (2 * HALF) @(posedge clk);
        #1;
        send_frame(8'h55, 0, 1, 0);
        check_state("start_stop_err");

        // Abandoned frame after 5 bits, then a valid 0x29.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        err_m++;
        repeat (TMO + 100) @(posedge clk);
        #1;
        check_state("timeout");
        send_frame(8'h29, 0, 0, 0);
        check("tmo_key", {24'h0, key}, 32'h29);
        check_state("after_timeout");
        drain();

        // Random frames with occasional errors.
        for (int n = 0; n < 24; n++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 7) == 0), 0);
            drain();
        end
        check_state("random");

        // Fill the FIFO, then overflow it.
        for (int n = 0; n < 8; n++) send_frame(8'($urandom_range(0, 255)), 0, 0, 0);
        check("full8_ovf", {31'h0, overflow}, 32'h0);
        check_state("full8");
        send_frame(8'($urandom_range(0, 255)), 0, 0, 0);
        check("full9_ovf", {31'h0, overflow}, 32'h1);
        check_state("full9");
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        ovf_m = 1'b0;
        check_state("clr_err");

        // Push and pop in the same cycle while full. One more push must then overflow.
        send_frame(8'($urandom_range(0, 255)), 0, 0, 1);
        check_state("full_push_pop");
        send_frame(8'($urandom_range(0, 255)), 0, 0, 0);
        check("still_full_ovf", {31'h0, overflow}, 32'h1);
        check_state("still_full");
        drain();
        check("drained_all", exp_q.size(), 32'h0);
        check_state("drained");

        // Reset in the middle of a frame.
        send_frame(8'h77, 0, 0, 0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        RSTN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        scan_m = 32'h0;
        ovf_m = 1'b0;
        check("midrst_key", {24'h0, key}, 32'h0);
        check("midrst_ready", {31'h0, ps2_ready}, 32'h0);
        check("midrst_ovf", {31'h0, overflow}, 32'h0);
        check("midrst_scan", Scancode, 32'h0);
        check("midrst_ferr", {31'h0, frame_err}, 32'h0);
        RSTN = 1'b1;
        repeat (TMO + 20) @(posedge clk);
        #1;
        check_state("post_rst");
        send_frame(8'h5A, 0, 0, 0);
        check("post_rst_key", {24'h0, key}, 32'h5A);
        check("post_rst_scan", Scancode, 32'h0000_005A);
        drain();
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
